// File: rtl/multicycle_computer_controller_main_fsm.sv
// rtl/multicycle_computer_controller_main_fsm.sv - main control FSM for a multicycle ARM-subset datapath
// Moore decodes of the registered state, plus memReady-gated fetch strobes and a registered retire pulse.
module multicycle_computer_controller_main_fsm #(
  parameter logic [3:0] s0 = 4'b0000,
  parameter logic [3:0] s1 = 4'b0001,
  parameter logic [3:0] s2 = 4'b0010,
  parameter logic [3:0] s3 = 4'b0011,
  parameter logic [3:0] s4 = 4'b0100,
  parameter logic [3:0] s5 = 4'b0101,
  parameter logic [3:0] s6 = 4'b0110,
  parameter logic [3:0] s7 = 4'b0111,
  parameter logic [3:0] s8 = 4'b1000,
  parameter logic [3:0] s9 = 4'b1001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] INSTRUCTION,
  input  logic        condEx,
  input  logic        memReady,
  output logic [3:0]  state,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        ALUOp,
  output logic        instrDone
);

  typedef enum logic [3:0] {
    FETCH    = s0,
    DECODE   = s1,
    MEMADR   = s2,
    MEMREAD  = s3,
    MEMWB    = s4,
    MEMWRITE = s5,
    EXECUTER = s6,
    EXECUTEI = s7,
    ALUWB    = s8,
    BRANCH   = s9
  } state_t;

  state_t state_q, state_d;
  logic   instr_done_q, instr_done_d;

  logic [1:0] op;
  logic       i_bit;
  logic       l_bit;
  logic [3:0] cmd;

  assign op    = INSTRUCTION[27:26];
  assign i_bit = INSTRUCTION[25];
  assign l_bit = INSTRUCTION[20];
  assign cmd   = INSTRUCTION[24:21];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_done_q <= instr_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        // IR and PC load only on the cycle the memory actually returns the word
        IRWrite   = memReady;
        PCWrite   = memReady;
        if (memReady) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (!condEx) begin
          state_d = FETCH;
        end else begin
          case (op)
            2'b01:   state_d = MEMADR;
            2'b00:   state_d = i_bit ? EXECUTEI : EXECUTER;
            2'b10:   state_d = BRANCH;
            default: state_d = FETCH;
          endcase
        end
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = l_bit ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (memReady) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (memReady) state_d = FETCH;
      end
      EXECUTER: begin
        ALUOp   = 1'b1;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
        state_d = ALUWB;
      end
      ALUWB: begin
        // TST/TEQ/CMP/CMN only update flags, never the register file
        RegWrite = (cmd[3:2] != 2'b10);
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign instr_done_d = (state_d == FETCH) && (state_q != FETCH);
  assign state        = state_q;
  assign instrDone    = instr_done_q;

endmodule

// File: tb/tb_multicycle_computer_controller_main_fsm.sv
// tb/tb_multicycle_computer_controller_main_fsm.sv - scoreboard bench for the multicycle main FSM
module tb_multicycle_computer_controller_main_fsm;

  logic        clk;
  logic        reset;
  logic [31:0] INSTRUCTION;
  logic        condEx;
  logic        memReady;
  logic [3:0]  state;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUOp, instrDone;
  logic [1:0]  ResultSrc, ALUSrcB;

  multicycle_computer_controller_main_fsm dut (
    .clk(clk), .reset(reset), .INSTRUCTION(INSTRUCTION), .condEx(condEx),
    .memReady(memReady), .state(state), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .instrDone(instrDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
  localparam logic [10:0] C_F1     = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 1'b0};
  localparam logic [10:0] C_F0     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 1'b0};
  localparam logic [10:0] C_DEC    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 1'b0};
  localparam logic [10:0] C_MADR   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0};
  localparam logic [10:0] C_MRD    = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
  localparam logic [10:0] C_MWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0};
  localparam logic [10:0] C_MWR    = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
  localparam logic [10:0] C_EXR    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1};
  localparam logic [10:0] C_EXI    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 1'b1};
  localparam logic [10:0] C_AWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0};
  localparam logic [10:0] C_AWB_NW = 11'b0;
  localparam logic [10:0] C_BR     = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 1'b0};

  localparam logic [31:0] I_ADD  = 32'hE0812002;
  localparam logic [31:0] I_ADDI = 32'hE2812001;
  localparam logic [31:0] I_LDR  = 32'hE5912000;
  localparam logic [31:0] I_STR  = 32'hE5812000;
  localparam logic [31:0] I_B    = 32'hEA000001;
  localparam logic [31:0] I_CMP  = 32'hE1510002;
  localparam logic [31:0] I_OP3  = 32'hEC000000;

  typedef struct packed {
    logic [3:0]  st;
    logic [10:0] ctl;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;

  // Inputs are applied just after a rising edge; the monitor checks the same cycle at the falling edge.
  task automatic step(input logic [31:0] ins, input logic ce, input logic mr, input logic rs,
                      input logic [3:0] es, input logic [10:0] ec, input logic ed);
    INSTRUCTION = ins;
    condEx      = ce;
    memReady    = mr;
    reset       = rs;
    exp_q.push_back('{st: es, ctl: ec, done: ed});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [10:0] act;
      e   = exp_q.pop_front();
      act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL state vec=%0d got=%0d exp=%0d", vec, state, e.st);
      end
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL ctl vec=%0d got=%b exp=%b", vec, act, e.ctl);
      end
      checks++;
      if (instrDone !== e.done) begin
        errors++;
        $display("FAIL instrDone vec=%0d got=%b exp=%b", vec, instrDone, e.done);
      end
      vec++;
    end
  end

  initial begin
    reset = 1'b1; INSTRUCTION = 32'h0; condEx = 1'b1; memReady = 1'b0;
    @(posedge clk);
    #1;
    // held in reset: FETCH decode, memReady still gates IRWrite/PCWrite
    step(I_ADD, 1, 0, 1, 4'd0, C_F0, 0);
    step(I_ADD, 1, 1, 1, 4'd0, C_F1, 0);
    step(I_ADD, 1, 0, 0, 4'd0, C_F0, 0);
    // ADD register: 0,1,6,8,0
    step(I_ADD, 1, 1, 0, 4'd0, C_F1, 0);
    step(I_ADD, 1, 0, 0, 4'd1, C_DEC, 0);
    step(I_ADD, 1, 0, 0, 4'd6, C_EXR, 0);
    step(I_ADD, 1, 0, 0, 4'd8, C_AWB, 0);
    step(I_ADD, 1, 0, 0, 4'd0, C_F0, 1);
    step(I_ADD, 1, 0, 0, 4'd0, C_F0, 0);
    // ADD immediate via EXECUTEI
    step(I_ADDI, 1, 1, 0, 4'd0, C_F1, 0);
    step(I_ADDI, 1, 0, 0, 4'd1, C_DEC, 0);
    step(I_ADDI, 1, 0, 0, 4'd7, C_EXI, 0);
    step(I_ADDI, 1, 0, 0, 4'd8, C_AWB, 0);
    step(I_ADDI, 1, 0, 0, 4'd0, C_F0, 1);
    // LDR with two wait cycles in MEMREAD
    step(I_LDR, 1, 1, 0, 4'd0, C_F1, 0);
    step(I_LDR, 1, 0, 0, 4'd1, C_DEC, 0);
    step(I_LDR, 1, 0, 0, 4'd2, C_MADR, 0);
    step(I_LDR, 1, 0, 0, 4'd3, C_MRD, 0);
    step(I_LDR, 1, 0, 0, 4'd3, C_MRD, 0);
    step(I_LDR, 1, 1, 0, 4'd3, C_MRD, 0);
    step(I_LDR, 1, 0, 0, 4'd4, C_MWB, 0);
    step(I_LDR, 1, 0, 0, 4'd0, C_F0, 1);
    // STR with one wait cycle, MemWrite held throughout
    step(I_STR, 1, 1, 0, 4'd0, C_F1, 0);
    step(I_STR, 1, 0, 0, 4'd1, C_DEC, 0);
    step(I_STR, 1, 0, 0, 4'd2, C_MADR, 0);
    step(I_STR, 1, 0, 0, 4'd5, C_MWR, 0);
    step(I_STR, 1, 1, 0, 4'd5, C_MWR, 0);
    step(I_STR, 1, 0, 0, 4'd0, C_F0, 1);
    // Branch
    step(I_B, 1, 1, 0, 4'd0, C_F1, 0);
    step(I_B, 1, 0, 0, 4'd1, C_DEC, 0);
    step(I_B, 1, 0, 0, 4'd9, C_BR, 0);
    step(I_B, 1, 0, 0, 4'd0, C_F0, 1);
    // Branch with condition failing: DECODE straight back to FETCH
    step(I_B, 1, 1, 0, 4'd0, C_F1, 0);
    step(I_B, 0, 0, 0, 4'd1, C_DEC, 0);
    step(I_B, 0, 0, 0, 4'd0, C_F0, 1);
    // op=11 treated as a no-op
    step(I_OP3, 1, 1, 0, 4'd0, C_F1, 0);
    step(I_OP3, 1, 0, 0, 4'd1, C_DEC, 0);
    step(I_OP3, 1, 0, 0, 4'd0, C_F0, 1);
    // CMP: no register write in ALUWB
    step(I_CMP, 1, 1, 0, 4'd0, C_F1, 0);
    step(I_CMP, 1, 0, 0, 4'd1, C_DEC, 0);
    step(I_CMP, 1, 0, 0, 4'd6, C_EXR, 0);
    step(I_CMP, 1, 0, 0, 4'd8, C_AWB_NW, 0);
    step(I_CMP, 1, 0, 0, 4'd0, C_F0, 1);
    // reset raised mid memory wait: immediate FETCH, no retire pulse
    step(I_LDR, 1, 1, 0, 4'd0, C_F1, 0);
    step(I_LDR, 1, 0, 0, 4'd1, C_DEC, 0);
    step(I_LDR, 1, 0, 0, 4'd2, C_MADR, 0);
    step(I_LDR, 1, 0, 0, 4'd3, C_MRD, 0);
    step(I_LDR, 1, 0, 1, 4'd0, C_F0, 0);
    step(I_LDR, 1, 0, 0, 4'd0, C_F0, 0);
    step(I_LDR, 1, 1, 0, 4'd0, C_F1, 0);
    step(I_LDR, 1, 0, 0, 4'd1, C_DEC, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_computer_controller_main_fsm.md
MULTICYCLE_COMPUTER_CONTROLLER_MAIN_FSM -- requirements
Module: multicycle_computer_controller_main_fsm

Interface
REQ-001 Clocking: one clock; reset is asynchronous and active-high.
REQ-002 Parameters (name, default, meaning), one 4-bit state code each:
- s0 4'b0000 FETCH
- s1 4'b0001 DECODE
- s2 4'b0010 MEMADR
- s3 4'b0011 MEMREAD
- s4 4'b0100 MEMWB
- s5 4'b0101 MEMWRITE
- s6 4'b0110 EXECUTER
- s7 4'b0111 EXECUTEI
- s8 4'b1000 ALUWB
- s9 4'b1001 BRANCH
- s10..s15: unused codes.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- INSTRUCTION  in  32  IR contents
- condEx  in  1  condition field passes against current flags
- memReady  in  1  memory completes access this cycle
- state  out  4  registered state code, consumed by flag-write decoder
- PCWrite  out  1  PC update enable
- AdrSrc  out  1  address select (0 = PC, 1 = ALU result)
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load enable
- RegWrite  out  1  register-file write enable
- ResultSrc  out  2  result select (00 ALUOut, 01 Data, 10 ALU)
- ALUSrcA  out  1  ALU A select (0 = Rn, 1 = PC)
- ALUSrcB  out  2  ALU B select (00 reg, 01 ExtImm, 10 const 4)
- ALUOp  out  1  1 = decode function from INSTRUCTION, 0 = add
- instrDone  out  1  registered one-cycle retire pulse

Function
REQ-004 state SHALL update only on rising clk; all other control outputs except instrDone SHALL be combinational decodes of state (Moore), with the memReady gating of REQ-013 and the INSTRUCTION gating of REQ-016.
REQ-005 Field use:
- op = INSTRUCTION[27:26]
- I = INSTRUCTION[25]
- L = INSTRUCTION[20]
- cmd = INSTRUCTION[24:21]
REQ-006 FETCH: memReady=1 -> DECODE; else hold FETCH.
REQ-007 DECODE transitions, evaluated in order:
- condEx=0 -> FETCH
- op=01 -> MEMADR
- op=00, I=0 -> EXECUTER
- op=00, I=1 -> EXECUTEI
- op=10 -> BRANCH
- op=11 -> FETCH (treated as no-op)
REQ-008 MEMADR: L=1 -> MEMREAD; L=0 -> MEMWRITE.
REQ-009 MEMREAD: memReady=1 -> MEMWB, else hold. MEMWRITE: memReady=1 -> FETCH, else hold.
REQ-010 EXECUTER and EXECUTEI -> ALUWB. MEMWB, ALUWB and BRANCH -> FETCH.
REQ-011 Unused codes s10..s15: all control outputs 0; next state FETCH.
REQ-012 Any output not listed for a state SHALL be 0.
REQ-013 FETCH outputs:
- AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0
- IRWrite=PCWrite=memReady, so IR and PC load exactly once, on the completing cycle.
REQ-014 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
REQ-015 Memory path:
- MEMADR: ALUSrcA=0, ALUSrcB=01
- MEMREAD: AdrSrc=1
- MEMWB: ResultSrc=01, RegWrite=1
- MEMWRITE: AdrSrc=1, MemWrite=1, held for every wait cycle.
REQ-016 ALU path:
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1
- ALUWB: ResultSrc=00; RegWrite=1 except RegWrite=0 when cmd[3:2]=10 (TST/TEQ/CMP/CMN).
REQ-017 BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=1.
REQ-018 instrDone SHALL be registered: it goes to 1 for exactly one cycle after any clocked transition into FETCH from a state other than FETCH. This includes condition-fail and op=11 exits from DECODE. Reset SHALL NOT produce a pulse.

Reset
REQ-019 reset=1 SHALL force state=s0 and instrDone=0 immediately, independent of clk, including mid-instruction and mid memory wait.
REQ-020 While reset=1, all control outputs SHALL be the FETCH decode with memReady gating; no other state is reachable.
REQ-021 First rising clk after reset deasserts SHALL apply the REQ-006 rule.

Verification
REQ-022 Register op: ADD, INSTRUCTION=32'hE0812002, condEx=1, memReady=1 -> states 0,1,6,8,0; RegWrite=1 only in s8; instrDone pulses once.
REQ-023 Load with wait: LDR, INSTRUCTION=32'hE5912000, memReady low 2 cycles in s3 -> s3 held 3 cycles; then s4 with ResultSrc=01 and RegWrite=1.
REQ-024 Store: STR, INSTRUCTION=32'hE5812000, memReady=0 for 1 cycle -> MemWrite=1 for both s5 cycles, then FETCH.
REQ-025 Branch and condition fail:
- B (INSTRUCTION=32'hEA000001) -> s9 with PCWrite=1.
- Same INSTRUCTION with condEx=0 -> s1 to s0 directly; instrDone pulses.
REQ-026 Compare and reset: CMP (INSTRUCTION=32'hE1510002) -> RegWrite=0 in s8. reset asserted in s3 -> state=0 before next clk edge; no instrDone pulse.
